pll_lf_sequencer: RTL and testbench

Controller for a Gowin PLL instance built with dynamic ICPSEL/LPFRES/LPFCAP inputs. It selects one of NUM_PROFILES loop-filter profiles and sequences PLL reset, settings application and lock acquisition, including timeout and bounded retry. It reports a qualified `ready` to downstream clock consumers. It sits beside the PLL wrapper in the board top level and runs on a free-running reference clock.

---
 rtl/pll_lf_pkg.sv | 31 +++
 rtl/pll_lock_sync.sv | 42 ++++
 rtl/pll_lf_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pll_lf_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lf_pkg.sv
// Shared types and helpers for the PLL loop-filter sequencer.
// Profile word layout: {icpsel[5:0], lpfres[2:0], lpfcap[1:0]}.
package pll_lf_pkg;

    localparam int ICP_W        = 6;
    localparam int RES_W        = 3;
    localparam int CAP_W        = 2;
    localparam int PROF_W       = ICP_W + RES_W + CAP_W;
    localparam int MAX_PROFILES = 256;

    typedef logic [2:0] state_t;

    localparam state_t ST_RST_HOLD  = 3'd0;
    localparam state_t ST_WAIT_LOCK = 3'd1;
    localparam state_t ST_QUALIFY   = 3'd2;
    localparam state_t ST_LOCKED    = 3'd3;
    localparam state_t ST_FAIL      = 3'd4;

    typedef struct packed {
        logic [ICP_W-1:0] icp;
        logic [RES_W-1:0] res;
        logic [CAP_W-1:0] cap;
    } lf_prof_t;

    // Table is passed zero-extended to MAX_PROFILES entries so one function serves any size.
    function automatic lf_prof_t prof_fields(input logic [MAX_PROFILES*PROF_W-1:0] tbl,
                                             input logic [7:0] idx);
        return tbl[int'(idx)*PROF_W +: PROF_W];
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Synchronises raw PLL lock and counts consecutive locked cycles.
// Latency: 2 cycles to lock_s; qualified on the LOCK_STABLE-th consecutive lock_s cycle.
// Backpressure: none; clear holds the run counter at zero.
module pll_lock_sync #(
    parameter int LOCK_STABLE = 256
) (
    input  logic clk,
    input  logic resetn,
    input  logic lock_raw,
    input  logic clear,
    output logic lock_s,
    output logic qualified
);
    localparam int RUN_W = $clog2(LOCK_STABLE + 1);

    logic             r_meta;
    logic             r_sync;
    logic [RUN_W-1:0] r_run;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= lock_raw;
            r_sync <= r_meta;
        end
    end

    // Saturates one short of LOCK_STABLE; the current lock_s cycle completes the run.
    always_ff @(posedge clk) begin
        if (!resetn || clear || !r_sync) begin
            r_run <= '0;
        end else if (r_run != RUN_W'(LOCK_STABLE - 1)) begin
            r_run <= r_run + 1'b1;
        end
    end

    assign lock_s    = r_sync;
    assign qualified = r_sync && (r_run == RUN_W'(LOCK_STABLE - 1));

endmodule

// File: rtl/pll_lf_sequencer.sv
// Gowin PLL loop-filter profile sequencer: reset, apply profile, qualify lock, bounded retry.
// Latency: req -> outputs 1 cycle; optional relock-on-loss enabled by PLL_LF_LOCK_MON_EN.
// Backpressure: req accepted only in LOCKED/FAIL; ignored while busy, bad index pulses bad_req.
module pll_lf_sequencer
    import pll_lf_pkg::*;
#(
    parameter int                               NUM_PROFILES    = 4,
    parameter logic [NUM_PROFILES*PROF_W-1:0]   PROFILE_TABLE   = {NUM_PROFILES{11'h000}},
    parameter int                               DEFAULT_PROFILE = 0,
    parameter int                               RST_CYCLES      = 16,
    parameter int                               LOCK_TIMEOUT    = 65536,
    parameter int                               LOCK_STABLE     = 256,
    parameter int                               MAX_RETRIES     = 3,
    localparam int PSEL_W = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
    localparam int ATT_W  = $clog2(MAX_RETRIES + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic [PSEL_W-1:0] prof_sel,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [ICP_W-1:0]  icpsel,
    output logic [RES_W-1:0]  lpfres,
    output logic [CAP_W-1:0]  lpfcap,
    output logic              ready,
    output logic              busy,
    output logic              fail,
    output logic              bad_req,
    output logic [PSEL_W-1:0] active_prof,
    output logic [ATT_W-1:0]  attempt
`ifdef PLL_LF_LOCK_MON_EN
    ,
    output logic [7:0]        relock_cnt
`endif
);
    localparam int CNT_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [MAX_PROFILES*PROF_W-1:0] TBL_EXT = (MAX_PROFILES*PROF_W)'(PROFILE_TABLE);
    localparam lf_prof_t DEF_FIELDS = prof_fields(TBL_EXT, 8'(DEFAULT_PROFILE));

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ATT_W-1:0]  r_attempt;
    logic [PSEL_W-1:0] r_active_prof;
    lf_prof_t          r_fields;
    logic              r_pll_reset;
    logic              r_busy;
    logic              r_ready;
    logic              r_fail;
    logic              r_bad_req;

    state_t            w_nxt_state;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic [ATT_W-1:0]  w_nxt_attempt;
    logic [ATT_W-1:0]  w_att_inc;
    logic [PSEL_W-1:0] w_nxt_prof;
    lf_prof_t          w_nxt_fields;
    logic              w_bad;
    logic              w_relock;
    logic              w_lock_s;
    logic              w_qualified;
    logic [31:0]       w_sel_ext;
    logic              w_sel_ok;

    pll_lock_sync #(
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_sync (
        .clk      (clk),
        .resetn   (resetn),
        .lock_raw (pll_lock),
        .clear    (r_state == ST_RST_HOLD),
        .lock_s   (w_lock_s),
        .qualified(w_qualified)
    );

    assign w_sel_ext    = {{(32-PSEL_W){1'b0}}, prof_sel};
    assign w_sel_ok     = (w_sel_ext < NUM_PROFILES);
    assign w_att_inc    = r_attempt + 1'b1;
    assign w_nxt_fields = prof_fields(TBL_EXT, 8'(w_nxt_prof));

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_nxt_attempt = r_attempt;
        w_nxt_prof    = r_active_prof;
        w_bad         = 1'b0;
        w_relock      = 1'b0;
        case (r_state)
            ST_RST_HOLD: begin
                if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                    w_nxt_state = ST_WAIT_LOCK;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK, ST_QUALIFY: begin
                // A lock that qualifies on the timeout cycle itself is kept.
                if (w_qualified) begin
                    w_nxt_state = ST_LOCKED;
                end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    w_nxt_cnt     = '0;
                    w_nxt_attempt = w_att_inc;
                    w_nxt_state   = (w_att_inc == ATT_W'(MAX_RETRIES)) ? ST_FAIL : ST_RST_HOLD;
                end else begin
                    w_nxt_cnt   = r_cnt + 1'b1;
                    w_nxt_state = w_lock_s ? ST_QUALIFY : ST_WAIT_LOCK;
                end
            end
            ST_LOCKED, ST_FAIL: begin
                if (req && w_sel_ok) begin
                    w_nxt_state   = ST_RST_HOLD;
                    w_nxt_cnt     = '0;
                    w_nxt_attempt = '0;
                    w_nxt_prof    = prof_sel;
                end else begin
                    w_bad = req;
`ifdef PLL_LF_LOCK_MON_EN
                    if (r_state == ST_LOCKED && !w_lock_s) begin
                        w_nxt_state   = ST_RST_HOLD;
                        w_nxt_cnt     = '0;
                        w_nxt_attempt = '0;
                        w_relock      = 1'b1;
                    end
`endif
                end
            end
            default: begin
                w_nxt_state = ST_RST_HOLD;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so the PLL reset pin never glitches.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= ST_RST_HOLD;
            r_cnt         <= '0;
            r_attempt     <= '0;
            r_active_prof <= PSEL_W'(DEFAULT_PROFILE);
            r_fields      <= DEF_FIELDS;
            r_pll_reset   <= 1'b1;
            r_busy        <= 1'b1;
            r_ready       <= 1'b0;
            r_fail        <= 1'b0;
            r_bad_req     <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_cnt         <= w_nxt_cnt;
            r_attempt     <= w_nxt_attempt;
            r_active_prof <= w_nxt_prof;
            r_pll_reset   <= (w_nxt_state == ST_RST_HOLD);
            r_busy        <= (w_nxt_state == ST_RST_HOLD) || (w_nxt_state == ST_WAIT_LOCK) ||
                             (w_nxt_state == ST_QUALIFY);
            r_ready       <= (w_nxt_state == ST_LOCKED);
            r_fail        <= (w_nxt_state == ST_FAIL);
            r_bad_req     <= w_bad;
            if (w_nxt_state == ST_RST_HOLD) begin
                r_fields <= w_nxt_fields;
            end
        end
    end

`ifdef PLL_LF_LOCK_MON_EN
    logic [7:0] r_relock_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_relock_cnt <= 8'd0;
        end else if (w_relock && r_relock_cnt != 8'hFF) begin
            r_relock_cnt <= r_relock_cnt + 8'd1;
        end
    end

    assign relock_cnt = r_relock_cnt;
`else
    logic w_unused_relock;
    assign w_unused_relock = w_relock;
`endif

    assign pll_reset   = r_pll_reset;
    assign icpsel      = r_fields.icp;
    assign lpfres      = r_fields.res;
    assign lpfcap      = r_fields.cap;
    assign ready       = r_ready;
    assign busy        = r_busy;
    assign fail        = r_fail;
    assign bad_req     = r_bad_req;
    assign active_prof = r_active_prof;
    assign attempt     = r_attempt;

endmodule

// File: tb/tb_pll_lf_sequencer.sv
// Bench for pll_lf_sequencer: RST_CYCLES=4, LOCK_TIMEOUT=64, LOCK_STABLE=8, MAX_RETRIES=2, 3 profiles.
// Observed outputs packed as {pll_reset, busy, ready, fail, bad_req, active_prof, attempt, icpsel, lpfres, lpfcap}.
module tb_pll_lf_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req;
    logic [1:0] prof_sel;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] icpsel;
    logic [2:0] lpfres;
    logic [1:0] lpfcap;
    logic       ready;
    logic       busy;
    logic       fail;
    logic       bad_req;
    logic [1:0] active_prof;
    logic [1:0] attempt;
`ifdef PLL_LF_LOCK_MON_EN
    logic [7:0] relock_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [20:0] sb_q [$];

    typedef struct {
        logic [1:0] sel;
        logic       exp_bad;
        logic [1:0] exp_prof;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    pll_lf_sequencer #(
        .NUM_PROFILES   (3),
        .PROFILE_TABLE  ({11'h333, 11'h222, 11'h111}),
        .DEFAULT_PROFILE(0),
        .RST_CYCLES     (4),
        .LOCK_TIMEOUT   (64),
        .LOCK_STABLE    (8),
        .MAX_RETRIES    (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .prof_sel   (prof_sel),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .icpsel     (icpsel),
        .lpfres     (lpfres),
        .lpfcap     (lpfcap),
        .ready      (ready),
        .busy       (busy),
        .fail       (fail),
        .bad_req    (bad_req),
        .active_prof(active_prof),
        .attempt    (attempt)
`ifdef PLL_LF_LOCK_MON_EN
        ,
        .relock_cnt (relock_cnt)
`endif
    );

    function automatic logic [10:0] prof_word(input logic [1:0] p);
        case (p)
            2'd0:    return 11'h111;
            2'd1:    return 11'h222;
            default: return 11'h333;
        endcase
    endfunction

    function automatic logic [20:0] mk(input logic rst, input logic bsy, input logic rdy,
                                       input logic fl, input logic bad,
                                       input logic [1:0] p, input logic [1:0] att);
        return {rst, bsy, rdy, fl, bad, p, att, prof_word(p)};
    endfunction

    function automatic logic [20:0] obs();
        return {pll_reset, busy, ready, fail, bad_req, active_prof, attempt, icpsel, lpfres, lpfcap};
    endfunction

    function automatic logic cond(input int which);
        case (which)
            0:       return !pll_reset;
            1:       return pll_reset;
            2:       return ready;
            3:       return !ready;
            default: return fail;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_obs(input string name, input logic [20:0] exp);
        n_checks++;
        if (obs() === exp) n_pass++;
        else $display("FAIL %s: got outputs %06h, expected %06h", name, obs(), exp);
    endtask

    task automatic sb_check(input string name);
        logic [20:0] e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got outputs %06h, expected an entry but scoreboard is empty", name, obs());
        end else begin
            e = sb_q.pop_front();
            check_obs(name, e);
        end
    endtask

    // Counts cycles until the selected condition holds; an expired bound returns the bound.
    task automatic wait_for(input int which, input int bound, output int n);
        n = 0;
        while (!cond(which) && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic relock(input string tag, input logic [1:0] p);
        int n;
        wait_for(0, 20, n);
        check({tag, "_rst_len"}, n, 4);
        tick();
        tick();
        pll_lock = 1'b1;
        wait_for(2, 100, n);
        check({tag, "_ready_lat"}, n, 10);
        check_obs({tag, "_locked"}, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, p, 2'd0));
    endtask

    task automatic issue_req(input logic [1:0] sel, input logic [20:0] exp, input string name);
        req      = 1'b1;
        prof_sel = sel;
        sb_q.push_back(exp);
        tick();
        req = 1'b0;
        sb_check(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

    initial begin
        int n;
        resetn   = 1'b0;
        req      = 1'b0;
        prof_sel = 2'd0;
        pll_lock = 1'b0;
        vecs[0] = '{sel: 2'd2, exp_bad: 1'b0, exp_prof: 2'd2};
        vecs[1] = '{sel: 2'd3, exp_bad: 1'b1, exp_prof: 2'd2};
        vecs[2] = '{sel: 2'd1, exp_bad: 1'b0, exp_prof: 2'd1};
        vecs[3] = '{sel: 2'd3, exp_bad: 1'b1, exp_prof: 2'd1};
        vecs[4] = '{sel: 2'd0, exp_bad: 1'b0, exp_prof: 2'd0};

        tick();
        tick();
        check_obs("reset", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        resetn = 1'b1;
        relock("boot", 2'd0);

        foreach (vecs[i]) begin
            if (!vecs[i].exp_bad) pll_lock = 1'b0;
            issue_req(vecs[i].sel,
                      vecs[i].exp_bad ? mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, vecs[i].exp_prof, 2'd0)
                                      : mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, vecs[i].exp_prof, 2'd0),
                      "req_resp");
            if (vecs[i].exp_bad) begin
                tick();
                check_obs("bad_pulse_end", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, vecs[i].exp_prof, 2'd0));
            end else begin
                relock("req", vecs[i].exp_prof);
            end
        end

        // Requests while busy are dropped silently, even out-of-range ones.
        pll_lock = 1'b0;
        req      = 1'b1;
        prof_sel = 2'd2;
        sb_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0));
        tick();
        sb_check("busy_accept");
        prof_sel = 2'd3;
        tick();
        check_obs("busy_bad_ignored", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0));
        prof_sel = 2'd1;
        tick();
        req = 1'b0;
        check_obs("busy_req_ignored", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0));
        wait_for(0, 20, n);
        check("busy_rst_len", n, 2);
        tick();
        tick();
        pll_lock = 1'b1;
        wait_for(2, 100, n);
        check("busy_ready_lat", n, 10);

        // One-cycle lock glitch during qualification restarts the stable run without a retry.
        pll_lock = 1'b0;
        issue_req(2'd1, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0), "glitch_accept");
        wait_for(0, 20, n);
        check("glitch_rst_len", n, 4);
        tick();
        tick();
        pll_lock = 1'b1;
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        wait_for(2, 100, n);
        check("glitch_ready_lat", n, 10);
        check_obs("glitch_no_retry", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0));

        // No lock at all: two timeouts then FAIL, and a valid request recovers.
        pll_lock = 1'b0;
        issue_req(2'd0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0), "tmo_accept");
        wait_for(0, 20, n);
        check("tmo_rst_len1", n, 4);
        wait_for(1, 100, n);
        check("tmo_len1", n, 64);
        check_obs("tmo_retry", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1));
        wait_for(0, 20, n);
        check("tmo_rst_len2", n, 4);
        wait_for(4, 100, n);
        check("tmo_len2", n, 64);
        check_obs("fail_state", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2));
        issue_req(2'd2, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0), "fail_recover");
        relock("recover", 2'd2);

`ifdef PLL_LF_LOCK_MON_EN
        pll_lock = 1'b0;
        wait_for(3, 20, n);
        check("lost_ready_lat", n, 3);
        check_obs("lost_relock", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0));
        check("relock_cnt_after_loss", int'(relock_cnt), 1);
        relock("auto", 2'd2);
        pll_lock = 1'b0;
        tick();
        tick();
        issue_req(2'd1, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0), "loss_with_req");
        check("relock_cnt_req_wins", int'(relock_cnt), 1);
        relock("simul", 2'd1);
`else
        pll_lock = 1'b0;
        repeat (6) tick();
        check_obs("lock_loss_ignored", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0));
        pll_lock = 1'b1;
`endif

        // Reset in the middle of a sequence returns to the default profile at once.
        pll_lock = 1'b0;
        issue_req(2'd1, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0), "abort_accept");
        wait_for(0, 20, n);
        tick();
        resetn = 1'b0;
        tick();
        check_obs("reset_abort", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        resetn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
